// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues one word read at a time, absorbs memory latency,
// and presents instructions in an IF/ID register that decode can stall or a redirect can flush.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [5:0]  opcode,
  output logic [5:0]  func
);

  typedef enum logic [1:0] {FETCH, WAIT, HOLD} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic        kill, kill_n;
  logic [31:0] hold_word, hold_word_n;
  logic        load;
  logic [31:0] load_word;
  logic        slot_free;
  logic [31:0] redirect_target;
  logic [31:0] pc_plus4;

  assign slot_free       = !if_valid || !stall;
  assign redirect_target = redirect_pc & ~32'h3;
  assign pc_plus4        = pc + 32'd4;

  // The request strobe is masked by reset so nothing is issued while held in reset.
  assign imem_req  = rst_n && (state == FETCH);
  assign imem_addr = pc;
  assign opcode    = if_instr[31:26];
  assign func      = if_instr[5:0];

  always_comb begin
    // NOTE: every variable gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    state_n     = state;
    pc_n        = pc;
    kill_n      = kill;
    hold_word_n = hold_word;
    load        = 1'b0;
    load_word   = hold_word;
    case (state)
      FETCH: begin
        state_n = WAIT;
        if (redirect) begin
          pc_n   = redirect_target;
          kill_n = 1'b1;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          // Any response here closes the outstanding request, stale or not.
          state_n = FETCH;
          kill_n  = 1'b0;
          if (redirect) begin
            pc_n = redirect_target;
          end else if (!kill) begin
            if (slot_free) begin
              load      = 1'b1;
              load_word = imem_rdata;
              pc_n      = pc_plus4;
            end else begin
              hold_word_n = imem_rdata;
              state_n     = HOLD;
            end
          end
        end else if (redirect) begin
          pc_n   = redirect_target;
          kill_n = 1'b1;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_n    = redirect_target;
          state_n = FETCH;
        end else if (slot_free) begin
          load    = 1'b1;
          pc_n    = pc_plus4;
          state_n = FETCH;
        end
      end
      default: state_n = FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      kill      <= 1'b0;
      hold_word <= 32'h0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      kill      <= kill_n;
      hold_word <= hold_word_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid    <= 1'b0;
      if_instr    <= 32'h0;
      if_pc       <= 32'h0;
      if_pc_plus4 <= 32'h0;
    end else if (redirect) begin
      if_valid <= 1'b0;
    end else if (load) begin
      if_valid    <= 1'b1;
      if_instr    <= load_word;
      if_pc       <= pc;
      if_pc_plus4 <= pc_plus4;
    end else if (if_valid && !stall) begin
      if_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed table, hand-written corner
// sequences, then random stall/redirect/latency traffic against an in-order stream model.
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall = 1'b0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [5:0]  opcode;
  logic [5:0]  func;

  int total = 0;
  int bad   = 0;

  instruction_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_pc_plus4 (if_pc_plus4),
    .opcode      (opcode),
    .func        (func)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rvalid;
    logic [31:0] rdata;
    logic        stall;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory contents as a fixed scramble of the address, so any word can be traced to its fetch address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_3C3C;
  endfunction

  task automatic check_ifid(input string name, input logic [31:0] pc, input logic [31:0] instr);
    logic [31:0] exp_instr;
    exp_instr = instr;
    check({name, "_valid"}, 32'(if_valid), 32'd1);
    check({name, "_pc"}, if_pc, pc);
    check({name, "_pc4"}, if_pc_plus4, pc + 32'd4);
    check({name, "_instr"}, if_instr, instr);
    check({name, "_opcode"}, 32'(opcode), 32'(exp_instr[31:26]));
    check({name, "_func"}, 32'(func), 32'(exp_instr[5:0]));
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic rv, input logic [31:0] rd, input logic st,
                       input logic rdr, input logic [31:0] rpc);
    imem_rvalid = rv;
    imem_rdata  = rd;
    stall       = st;
    redirect    = rdr;
    redirect_pc = rpc;
    @(negedge clk);
  endtask

  // Leaves the bench at the start of the first cycle after reset release.
  task automatic reset_dut();
    rst_n       = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    stall       = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_pc", if_pc, 32'h0);
    check("rst_pc4", if_pc_plus4, 32'h0);
    check("rst_instr", if_instr, 32'h0);
    rst_n = 1'b1;
  endtask

  vec_t vecs[10];

  logic        pending;
  logic [31:0] pend_addr;
  int          cnt;
  logic [31:0] exp_next;
  int          consumed;
  logic        prev_redirect;
  logic        prev_hold;
  logic [31:0] prev_pc, prev_pc4, prev_instr;

  initial begin
    // Basic fetch with a 1-cycle memory, then a 5-cycle stall forcing the next word into the buffer.
    vecs[0] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
    vecs[1] = '{1'b1, 32'h0000_0020, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
    vecs[2] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h4, 1'b1, 32'h0, 32'h0000_0020};
    vecs[3] = '{1'b1, 32'h8C43_0004, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 32'h0000_0020};
    vecs[4] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 32'h0000_0020};
    vecs[5] = '{1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 32'h0000_0020};
    vecs[6] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 32'h0000_0020};
    vecs[7] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 32'h0000_0020};
    vecs[8] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h8, 1'b1, 32'h4, 32'h8C43_0004};
    vecs[9] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0};

    reset_dut();
    for (int i = 0; i < 10; i++) begin
      apply(vecs[i].rvalid, vecs[i].rdata, vecs[i].stall, 1'b0, 32'h0);
      check($sformatf("tbl%0d_req", i), 32'(imem_req), 32'(vecs[i].exp_req));
      if (vecs[i].exp_req) check($sformatf("tbl%0d_addr", i), imem_addr, vecs[i].exp_addr);
      check($sformatf("tbl%0d_valid", i), 32'(if_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) check_ifid($sformatf("tbl%0d", i), vecs[i].exp_pc, vecs[i].exp_instr);
      adv();
    end

    // Redirect while a 3-cycle response is pending.
    reset_dut();
    apply(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("rw_req0", 32'(imem_req), 32'd1);
    check("rw_addr0", imem_addr, RESET_PC);
    adv();
    apply(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    adv();
    apply(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0103);
    adv();
    apply(1'b1, 32'hBAD0_0001, 1'b0, 1'b0, 32'h0);
    check("rw_valid3", 32'(if_valid), 32'd0);
    adv();
    apply(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("rw_req4", 32'(imem_req), 32'd1);
    check("rw_addr4", imem_addr, 32'h0000_0100);
    check("rw_valid4", 32'(if_valid), 32'd0);
    adv();
    apply(1'b1, 32'h2001_0100, 1'b0, 1'b0, 32'h0);
    check("rw_valid5", 32'(if_valid), 32'd0);
    adv();
    apply(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_ifid("rw_word", 32'h0000_0100, 32'h2001_0100);
    check("rw_addr6", imem_addr, 32'h0000_0104);
    adv();

    // Redirect coincident with the response.
    apply(1'b1, 32'hBAD0_0002, 1'b0, 1'b1, 32'h0000_0200);
    adv();
    apply(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("co_valid", 32'(if_valid), 32'd0);
    check("co_req", 32'(imem_req), 32'd1);
    check("co_addr", imem_addr, 32'h0000_0200);
    adv();
    apply(1'b1, 32'h0000_0008, 1'b0, 1'b0, 32'h0);
    adv();

    // Redirect in FETCH to the top word, then wrap of the increment.
    apply(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    check_ifid("co_word", 32'h0000_0200, 32'h0000_0008);
    adv();
    apply(1'b1, 32'hBAD0_0003, 1'b0, 1'b0, 32'h0);
    check("wr_flush", 32'(if_valid), 32'd0);
    adv();
    apply(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("wr_addr_top", imem_addr, 32'hFFFF_FFFC);
    check("wr_valid", 32'(if_valid), 32'd0);
    adv();
    apply(1'b1, 32'h0800_0040, 1'b0, 1'b0, 32'h0);
    adv();
    apply(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_ifid("wr_word", 32'hFFFF_FFFC, 32'h0800_0040);
    check("wr_pc4_zero", if_pc_plus4, 32'h0);
    check("wr_req", 32'(imem_req), 32'd1);
    check("wr_addr_zero", imem_addr, 32'h0);
    adv();

    // Reset while in WAIT, with the abandoned response arriving afterwards.
    reset_dut();
    apply(1'b1, 32'hBAD0_0004, 1'b0, 1'b0, 32'h0);
    check("mr_req", 32'(imem_req), 32'd1);
    check("mr_addr", imem_addr, RESET_PC);
    adv();
    apply(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("mr_valid1", 32'(if_valid), 32'd0);
    adv();
    apply(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("mr_valid2", 32'(if_valid), 32'd0);
    adv();

    // Random traffic: the consumed stream must be sequential from the last redirect target.
    reset_dut();
    pending       = 1'b0;
    pend_addr     = 32'h0;
    cnt           = 0;
    exp_next      = RESET_PC;
    consumed      = 0;
    prev_redirect = 1'b0;
    prev_hold     = 1'b0;
    prev_pc       = 32'h0;
    prev_pc4      = 32'h0;
    prev_instr    = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      if (pending) begin
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(pend_addr);
          pending     = 1'b0;
        end else begin
          cnt--;
        end
      end
      stall       = ($urandom_range(0, 2) == 0);
      redirect    = ($urandom_range(0, 11) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : 32'($urandom);
      @(negedge clk);
      if (prev_redirect) check("rnd_flush", 32'(if_valid), 32'd0);
      if (prev_hold) begin
        check("rnd_hold_valid", 32'(if_valid), 32'd1);
        check("rnd_hold_pc", if_pc, prev_pc);
        check("rnd_hold_pc4", if_pc_plus4, prev_pc4);
        check("rnd_hold_instr", if_instr, prev_instr);
      end
      if (imem_req) begin
        check("rnd_one_outstanding", 32'(pending), 32'd0);
        check("rnd_align", 32'(imem_addr[1:0]), 32'd0);
        pending   = 1'b1;
        pend_addr = imem_addr;
        cnt       = int'($urandom_range(0, 3));
      end
      if (if_valid) begin
        check("rnd_word", if_instr, mem_word(if_pc));
        check("rnd_pc4", if_pc_plus4, if_pc + 32'd4);
      end
      if (if_valid && !stall && !redirect) begin
        check("rnd_order", if_pc, exp_next);
        exp_next = if_pc + 32'd4;
        consumed++;
      end
      if (redirect) exp_next = redirect_pc & ~32'h3;
      prev_redirect = redirect;
      prev_hold     = if_valid && stall && !redirect;
      prev_pc       = if_pc;
      prev_pc4      = if_pc_plus4;
      prev_instr    = if_instr;
      adv();
    end
    check("rnd_progress", 32'(consumed > 200), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port imem_req, output, 1 bit: instruction-memory read request, one cycle per request.
REQ-006 The block SHALL have port imem_addr, output, 32 bits: the word-aligned fetch address, valid while imem_req=1.
REQ-007 The block SHALL have port imem_rvalid, input, 1 bit: memory response strobe, arriving 1 or more cycles after a request.
REQ-008 The block SHALL have port imem_rdata, input, 32 bits: instruction word, valid while imem_rvalid=1.
REQ-009 The block SHALL have port redirect, input, 1 bit: branch, jump or jr taken, which redirects the PC and flushes.
REQ-010 The block SHALL have port redirect_pc, input, 32 bits: the redirect target address.
REQ-011 The block SHALL have port stall, input, 1 bit: decode is not ready to consume the IF/ID word.
REQ-012 The block SHALL have port if_valid, output, 1 bit: the IF/ID register holds a valid instruction.
REQ-013 The block SHALL have port if_instr, output, 32 bits: the IF/ID instruction word.
REQ-014 The block SHALL have port if_pc, output, 32 bits: the address of if_instr.
REQ-015 The block SHALL have port if_pc_plus4, output, 32 bits: if_pc+4, modulo 2^32.
REQ-016 The block SHALL have port opcode, output, 6 bits: if_instr[31:26], driving decode.
REQ-017 The block SHALL have port func, output, 6 bits: if_instr[5:0], driving decode.

Function
REQ-018 The block SHALL implement three states: FETCH, WAIT and HOLD.
REQ-019 The block SHALL keep at most one memory request outstanding.
REQ-020 In FETCH, the block SHALL drive imem_req=1 and imem_addr=pc, then move to WAIT unconditionally.
REQ-021 In WAIT, on imem_rvalid with kill=0 and no redirect, if the slot is free, the block SHALL load IF/ID, set pc<=pc+4 and go to FETCH.
REQ-022 The IF/ID slot SHALL be free when if_valid=0 or stall=0.
REQ-023 In WAIT, on imem_rvalid with kill=0 and no redirect, if the slot is not free, the block SHALL capture imem_rdata into a 1-entry buffer and go to HOLD.
REQ-024 In HOLD, once the slot is free, the block SHALL load IF/ID from the buffer, set pc<=pc+4 and go to FETCH.
REQ-025 On consumption (if_valid=1, stall=0) with no new load in that cycle, if_valid SHALL be 0 on the next cycle.
REQ-026 While stall=1, if_valid, if_instr, if_pc and if_pc_plus4 SHALL hold stable.
REQ-027 On redirect=1, the block SHALL set pc<=redirect_pc with bits [1:0] forced to 0, and clear if_valid next cycle; redirect SHALL take priority over stall.
REQ-028 Redirect in FETCH SHALL issue the request, set kill=1 and go to WAIT.
REQ-029 Redirect in WAIT without imem_rvalid SHALL set kill=1 and stay in WAIT.
REQ-030 Redirect in WAIT coincident with imem_rvalid SHALL discard the response, leave kill=0 and go to FETCH.
REQ-031 Redirect in HOLD SHALL discard the buffer and go to FETCH.
REQ-032 imem_rvalid with kill=1 SHALL discard the response, clear kill and go to FETCH; pc SHALL be unchanged.
REQ-033 A redirect while kill=1 SHALL update pc and leave kill=1.
REQ-034 PC increment SHALL wrap: 32'hFFFF_FFFC+4 SHALL give 32'h0000_0000, and the same rule applies to if_pc_plus4.
REQ-035 opcode and func SHALL be combinational slices of if_instr.
REQ-036 imem_rvalid outside WAIT SHALL be ignored.

Reset
REQ-037 While rst_n=0, the block SHALL hold: state=FETCH, pc=RESET_PC, kill=0, buffer=0, if_valid=0, if_instr=0, if_pc=0, if_pc_plus4=0, imem_req=0.
REQ-038 The first imem_req SHALL be issued in the first clock cycle after rst_n deasserts.
REQ-039 Reset asserted mid-operation SHALL abandon any outstanding request.
REQ-040 After reset, a response to an abandoned request SHALL be ignored, because the block is in FETCH.

Verification
REQ-041 The bench SHALL cover basic fetch: reset release, 1-cycle memory returning 32'h0000_0020 -> imem_addr=0 at cycle 0, if_valid=1 at cycle 2 with if_pc=0, if_pc_plus4=4, opcode=0, func=6'h20.
REQ-042 The bench SHALL cover stall: stall=1 held for 5 cycles after if_valid, with the next word returned -> IF/ID stable, block in HOLD, no imem_req; stall=0 -> next word at pc=4 appears the following cycle.
REQ-043 The bench SHALL cover redirect during WAIT: redirect=1 with redirect_pc=32'h0000_0103 while a 3-cycle response is pending -> the response is discarded, next imem_addr=32'h0000_0100, and if_valid stays 0 until that word returns.
REQ-044 The bench SHALL cover coincident events: redirect and imem_rvalid in the same cycle -> IF/ID is not loaded and the next request goes to redirect_pc.
REQ-045 The bench SHALL cover wrap: redirect_pc=32'hFFFF_FFFC -> if_pc=32'hFFFF_FFFC, if_pc_plus4=0, and next imem_addr=0.
REQ-046 The bench SHALL cover reset mid-operation: rst_n low while in WAIT, followed by a late imem_rvalid -> the late response is ignored, the first request goes to RESET_PC, and if_valid=0.
